// File: rtl/vend_pkg.sv
// Shared vending definitions: coin values, coin_req bit positions and
// dispenser state encoding, using the same coin naming as the acceptor FSM.
package vend_pkg;

    localparam logic [7:0] NICKLE_C = 8'd5;
    localparam logic [7:0] DIME_C   = 8'd10;
    localparam logic [7:0] QUATER_C = 8'd25;

    localparam int CR_N = 0;
    localparam int CR_D = 1;
    localparam int CR_Q = 2;

    typedef logic [2:0] coin_req_t;

    localparam coin_req_t COIN_NONE = 3'b000;
    localparam coin_req_t COIN_N    = 3'b001;
    localparam coin_req_t COIN_D    = 3'b010;
    localparam coin_req_t COIN_Q    = 3'b100;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SELECT = 2'b01;
    localparam logic [1:0] ST_DISP   = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    // Cent value of a one-hot coin request; anything not one-hot is worth nothing.
    function automatic logic [7:0] coin_value(input coin_req_t req);
        logic [7:0] val;
        case (req)
            COIN_Q:  val = QUATER_C;
            COIN_D:  val = DIME_C;
            COIN_N:  val = NICKLE_C;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change request handshake and coin hopper signals of the change dispenser.
// master = vending controller plus hopper side, slave = the dispenser.
interface change_dispenser_if #(parameter int AMT_W = 6);
    import vend_pkg::*;

    logic             change_valid;
    logic [AMT_W-1:0] change_amt;
    logic             change_ready;
    logic             quater_empty;
    logic             dime_empty;
    logic             nickle_empty;
    logic             coin_ack;
    coin_req_t        coin_req;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] paid_amt;

    modport master (
        output change_valid, change_amt, quater_empty, dime_empty, nickle_empty, coin_ack,
        input  change_ready, coin_req, busy, done, short, paid_amt
    );

    modport slave (
        input  change_valid, change_amt, quater_empty, dime_empty, nickle_empty, coin_ack,
        output change_ready, coin_req, busy, done, short, paid_amt
    );

endinterface

// File: rtl/change_ack_timer.sv
// Coin acknowledge watchdog: synchronous clear, count enable and a registered
// terminal-count flag that is high while the count equals ACK_TIMEOUT-1.
module change_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             TW     = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TC_VAL = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]  ONE    = TW'(32'd1);

    logic [TW-1:0] cnt_r;
    logic [TW-1:0] cnt_n;
    logic          tc_r;

    // Next count: clear wins, then saturating increment at the terminal value.
    always_comb begin
        cnt_n = cnt_r;
        if (clr) begin
            cnt_n = '0;
        end else if (en && (cnt_r != TC_VAL)) begin
            cnt_n = cnt_r + ONE;
        end else begin
            cnt_n = cnt_r;
        end
    end

    // Count register and the flag that mirrors it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            tc_r  <= 1'b0;
        end else begin
            cnt_r <= cnt_n;
            tc_r  <= (cnt_n == TC_VAL);
        end
    end

    assign tc = tc_r;

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin-change dispenser: pays an amount as quarters, dimes, nickels one
// coin at a time over a req/ack hopper handshake, skipping empty tubes.
module change_dispenser #(
    parameter int AMT_W       = 6,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    change_dispenser_if.slave   bus
);
    import vend_pkg::*;

    localparam logic [AMT_W-1:0] Q_AMT = AMT_W'(QUATER_C);
    localparam logic [AMT_W-1:0] D_AMT = AMT_W'(DIME_C);
    localparam logic [AMT_W-1:0] N_AMT = AMT_W'(NICKLE_C);

    logic [1:0]       state_r, state_n;
    logic [AMT_W-1:0] rem_r, rem_n;
    logic [AMT_W-1:0] paid_r, paid_n;
    coin_req_t        coin_r, coin_n;
    logic             done_r, short_r, busy_r, ready_r;
    logic             tmr_clr_s, tmr_en_s, tmr_tc_s;
    logic [AMT_W-1:0] coin_val_s;

    assign coin_val_s = AMT_W'(coin_value(coin_r));

    change_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .tc    (tmr_tc_s)
    );

    // Next-state logic; empty flags only matter in SELECT, ack only in DISP.
    always_comb begin
        state_n   = state_r;
        rem_n     = rem_r;
        paid_n    = paid_r;
        coin_n    = coin_r;
        tmr_clr_s = 1'b0;
        tmr_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                coin_n = COIN_NONE;
                if (bus.change_valid) begin
                    rem_n   = bus.change_amt;
                    paid_n  = '0;
                    state_n = ST_SELECT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SELECT: begin
                tmr_clr_s = 1'b1;
                if ((rem_r >= Q_AMT) && !bus.quater_empty) begin
                    coin_n  = COIN_Q;
                    state_n = ST_DISP;
                end else if ((rem_r >= D_AMT) && !bus.dime_empty) begin
                    coin_n  = COIN_D;
                    state_n = ST_DISP;
                end else if ((rem_r >= N_AMT) && !bus.nickle_empty) begin
                    coin_n  = COIN_N;
                    state_n = ST_DISP;
                end else begin
                    coin_n  = COIN_NONE;
                    state_n = ST_DONE;
                end
            end
            ST_DISP: begin
                if (bus.coin_ack) begin
                    rem_n   = rem_r - coin_val_s;
                    paid_n  = paid_r + coin_val_s;
                    coin_n  = COIN_NONE;
                    state_n = ST_SELECT;
                end else if (tmr_tc_s) begin
                    coin_n  = COIN_NONE;
                    state_n = ST_DONE;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                coin_n  = COIN_NONE;
                state_n = ST_IDLE;
            end
            default: begin
                coin_n  = COIN_NONE;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; status flags follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            rem_r   <= '0;
            paid_r  <= '0;
            coin_r  <= COIN_NONE;
            done_r  <= 1'b0;
            short_r <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_n;
            rem_r   <= rem_n;
            paid_r  <= paid_n;
            coin_r  <= coin_n;
            done_r  <= (state_n == ST_DONE);
            short_r <= (state_n == ST_DONE) && (rem_n >= N_AMT);
            busy_r  <= (state_n != ST_IDLE);
            ready_r <= (state_n == ST_IDLE);
        end
    end

    assign bus.change_ready = ready_r;
    assign bus.coin_req     = coin_r;
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.short        = short_r;
    assign bus.paid_amt     = paid_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy order, empty tubes, residue,
// ack timeout and asynchronous reset in the middle of a payout.
module tb_change_dispenser;

    localparam int AMT_W = 6;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [2:0]       coin_log [8];
    int               start_log[8];
    int               hold_log [8];
    int               ncoins;
    logic [AMT_W-1:0] paid_seen;
    logic             short_seen;
    int               done_cyc;
    bit               got_done;

    change_dispenser_if #(.AMT_W(AMT_W)) bus ();

    change_dispenser #(.AMT_W(AMT_W), .ACK_TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request, act as the hopper, and log coins until done or a budget runs out.
    // Cycle c=0 is the cycle right after the edge that takes the request.
    task automatic dispense(input logic [AMT_W-1:0] amt, input bit ack_en);
        int age;
        age = 0; ncoins = 0; got_done = 0; done_cyc = -1;
        paid_seen = 'x; short_seen = 1'bx;
        for (int i = 0; i < 8; i++) begin
            coin_log[i] = 3'b000; start_log[i] = -1; hold_log[i] = -1;
        end
        @(posedge clk); #1;
        bus.change_valid = 1'b1; bus.change_amt = amt;
        @(posedge clk); #1;
        bus.change_valid = 1'b0; bus.change_amt = 6'd0;
        for (int c = 0; c < 200 && !got_done; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            bus.coin_ack = 1'b0;
            if (bus.coin_req != 3'b000) begin
                if (age == 0) begin
                    if (ncoins < 8) begin coin_log[ncoins] = bus.coin_req; start_log[ncoins] = c; end
                    ncoins++;
                end
                age++;
                if (ack_en && age == 2) bus.coin_ack = 1'b1;
            end else begin
                if (age != 0 && ncoins > 0 && ncoins <= 8) hold_log[ncoins-1] = age;
                age = 0;
            end
            if (bus.done) begin
                got_done = 1; done_cyc = c; paid_seen = bus.paid_amt; short_seen = bus.short;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.change_valid = 1'b0; bus.change_amt = 6'd0; bus.coin_ack = 1'b0;
        bus.quater_empty = 1'b0; bus.dime_empty = 1'b0; bus.nickle_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.coin_req !== 3'b000) begin errors++; $display("FAIL rst_coin_req got=%b exp=000", bus.coin_req); end
        checks++; if (bus.change_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.change_ready); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.short !== 1'b0) begin errors++; $display("FAIL rst_flags got busy=%b done=%b short=%b exp=0", bus.busy, bus.done, bus.short); end
        checks++; if (bus.paid_amt !== 6'd0) begin errors++; $display("FAIL rst_paid got=%0d exp=0", bus.paid_amt); end
        rst_n = 1'b1;
    endtask

    task automatic test_greedy_40;
        logic [2:0] exp_c[3];
        exp_c[0] = 3'b100; exp_c[1] = 3'b010; exp_c[2] = 3'b001;
        dispense(6'd40, 1'b1);
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL g40_timeout got=%b exp=1", got_done); end
        checks++; if (ncoins !== 3) begin errors++; $display("FAIL g40_ncoins got=%0d exp=3", ncoins); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (coin_log[i] !== exp_c[i]) begin errors++; $display("FAIL g40_coin%0d got=%b exp=%b", i, coin_log[i], exp_c[i]); end
            checks++; if (start_log[i] !== 1 + 3*i) begin errors++; $display("FAIL g40_start%0d got=%0d exp=%0d", i, start_log[i], 1 + 3*i); end
        end
        checks++; if (paid_seen !== 6'd40) begin errors++; $display("FAIL g40_paid got=%0d exp=40", paid_seen); end
        checks++; if (short_seen !== 1'b0) begin errors++; $display("FAIL g40_short got=%b exp=0", short_seen); end
        checks++; if (done_cyc !== 10) begin errors++; $display("FAIL g40_done_cyc got=%0d exp=10", done_cyc); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0 || bus.change_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL g40_after got done=%b ready=%b busy=%b exp 0/1/0", bus.done, bus.change_ready, bus.busy); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.paid_amt !== 6'd40) begin errors++; $display("FAIL g40_paid_hold got=%0d exp=40", bus.paid_amt); end
    endtask

    task automatic test_quarter_empty_30;
        bus.quater_empty = 1'b1;
        dispense(6'd30, 1'b1);
        bus.quater_empty = 1'b0;
        checks++; if (ncoins !== 3) begin errors++; $display("FAIL qe30_ncoins got=%0d exp=3", ncoins); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (coin_log[i] !== 3'b010) begin errors++; $display("FAIL qe30_coin%0d got=%b exp=010", i, coin_log[i]); end
        end
        checks++; if (paid_seen !== 6'd30 || short_seen !== 1'b0) begin errors++; $display("FAIL qe30_result got paid=%0d short=%b exp 30/0", paid_seen, short_seen); end
    endtask

    task automatic test_no_coins_15;
        bus.dime_empty = 1'b1; bus.nickle_empty = 1'b1;
        dispense(6'd15, 1'b1);
        bus.dime_empty = 1'b0; bus.nickle_empty = 1'b0;
        checks++; if (ncoins !== 0) begin errors++; $display("FAIL nc15_ncoins got=%0d exp=0", ncoins); end
        checks++; if (done_cyc !== 1) begin errors++; $display("FAIL nc15_done_cyc got=%0d exp=1", done_cyc); end
        checks++; if (paid_seen !== 6'd0) begin errors++; $display("FAIL nc15_paid got=%0d exp=0", paid_seen); end
        checks++; if (short_seen !== 1'b1) begin errors++; $display("FAIL nc15_short got=%b exp=1", short_seen); end
    endtask

    task automatic test_max_63;
        logic [2:0] exp_c[3];
        exp_c[0] = 3'b100; exp_c[1] = 3'b100; exp_c[2] = 3'b010;
        dispense(6'd63, 1'b1);
        checks++; if (ncoins !== 3) begin errors++; $display("FAIL m63_ncoins got=%0d exp=3", ncoins); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (coin_log[i] !== exp_c[i]) begin errors++; $display("FAIL m63_coin%0d got=%b exp=%b", i, coin_log[i], exp_c[i]); end
        end
        checks++; if (paid_seen !== 6'd60) begin errors++; $display("FAIL m63_paid got=%0d exp=60", paid_seen); end
        checks++; if (short_seen !== 1'b0) begin errors++; $display("FAIL m63_short got=%b exp=0", short_seen); end
    endtask

    task automatic test_ack_timeout;
        dispense(6'd10, 1'b0);
        checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL to10_no_done got=%b exp=1", got_done); end
        checks++; if (ncoins !== 1 || coin_log[0] !== 3'b010) begin errors++; $display("FAIL to10_coin got n=%0d coin=%b exp 1/010", ncoins, coin_log[0]); end
        checks++; if (hold_log[0] !== 16) begin errors++; $display("FAIL to10_hold got=%0d exp=16", hold_log[0]); end
        checks++; if (done_cyc !== 17) begin errors++; $display("FAIL to10_done_cyc got=%0d exp=17", done_cyc); end
        checks++; if (paid_seen !== 6'd0 || short_seen !== 1'b1) begin errors++; $display("FAIL to10_result got paid=%0d short=%b exp 0/1", paid_seen, short_seen); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        bus.change_valid = 1'b1; bus.change_amt = 6'd50;
        @(posedge clk); #1;
        bus.change_valid = 1'b0; bus.change_amt = 6'd0;
        @(posedge clk); #1;
        checks++; if (bus.coin_req !== 3'b100) begin errors++; $display("FAIL rm_first got=%b exp=100", bus.coin_req); end
        @(posedge clk); #1;
        bus.coin_ack = 1'b1;
        @(posedge clk); #1;
        bus.coin_ack = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.coin_req !== 3'b100) begin errors++; $display("FAIL rm_second got=%b exp=100", bus.coin_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.coin_req !== 3'b000 || bus.busy !== 1'b0 || bus.change_ready !== 1'b1) begin errors++; $display("FAIL rm_async got req=%b busy=%b ready=%b exp 000/0/1", bus.coin_req, bus.busy, bus.change_ready); end
        checks++; if (bus.paid_amt !== 6'd0 || bus.done !== 1'b0 || bus.short !== 1'b0) begin errors++; $display("FAIL rm_async_data got paid=%0d done=%b short=%b exp 0/0/0", bus.paid_amt, bus.done, bus.short); end
        #1;
        rst_n = 1'b1;
        dispense(6'd5, 1'b1);
        checks++; if (ncoins !== 1 || coin_log[0] !== 3'b001) begin errors++; $display("FAIL rm_n5_coin got n=%0d coin=%b exp 1/001", ncoins, coin_log[0]); end
        checks++; if (paid_seen !== 6'd5 || short_seen !== 1'b0) begin errors++; $display("FAIL rm_n5_result got paid=%0d short=%b exp 5/0", paid_seen, short_seen); end
        checks++; if (done_cyc !== 4) begin errors++; $display("FAIL rm_n5_done_cyc got=%0d exp=4", done_cyc); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_greedy_40();
        test_quarter_empty_30();
        test_no_coins_15();
        test_max_63();
        test_ack_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
